// File: rtl/rfphoenix_ichit_plru_pkg.sv
// Shared I-cache geometry constants and types for the rfPhoenix hit / way-select logic.
package rfphoenix_ichit_plru_pkg;

  localparam int ICACHE_LINES = 128;
  localparam int ICACHE_WAYS  = 4;
  localparam int ICACHE_AWID  = 32;
  localparam int ICACHE_LOBIT = 6;

  typedef logic [ICACHE_AWID-1:ICACHE_LOBIT]   ic_tag_t;
  typedef logic [$clog2(ICACHE_WAYS)-1:0]      ic_way_t;

endpackage

// File: rtl/rfphoenix_plru_tree.sv
// Per-set tree pseudo-LRU state: a node bit of 1 sends the victim walk to the upper half.
module rfphoenix_plru_tree #(
  parameter  int LINES = 128,
  parameter  int WAYS  = 4,
  localparam int IDXW  = $clog2(LINES),
  localparam int WAYW  = $clog2(WAYS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            hit_v,
  input  logic [IDXW-1:0] hit_idx,
  input  logic [WAYW-1:0] hit_way,
  input  logic            fill_v,
  input  logic [IDXW-1:0] fill_idx,
  input  logic [WAYW-1:0] fill_way,
  input  logic [IDXW-1:0] rd_idx,
  output logic [WAYW-1:0] victim
);

  typedef logic [WAYS-2:0] node_t;

  node_t tree [LINES];
  node_t hit_next;
  node_t fill_base;
  node_t fill_next;

  // Walk root-to-leaf along the touched way, pointing every node on the path away from it.
  function automatic node_t touch(input node_t cur, input logic [WAYW-1:0] way);
    node_t n;
    int    node;
    n    = cur;
    node = 0;
    for (int l = 0; l < WAYW; l++) begin
      n[node] = ~way[WAYW-1-l];
      node    = 2 * node + 1 + int'(way[WAYW-1-l]);
    end
    return n;
  endfunction

  function automatic logic [WAYW-1:0] pick(input node_t cur);
    logic [WAYW-1:0] v;
    int              node;
    v    = '0;
    node = 0;
    for (int l = 0; l < WAYW; l++) begin
      v[WAYW-1-l] = cur[node];
      node        = 2 * node + 1 + int'(cur[node]);
    end
    return v;
  endfunction

  // A fill on the set being hit this cycle builds on the hit-updated bits.
  always_comb begin
    hit_next  = touch(tree[hit_idx], hit_way);
    fill_base = (hit_v && (hit_idx == fill_idx)) ? hit_next : tree[fill_idx];
    fill_next = touch(fill_base, fill_way);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LINES; i++) tree[i] <= '0;
    end else begin
      if (hit_v)  tree[hit_idx]  <= hit_next;
      if (fill_v) tree[fill_idx] <= fill_next;
    end
  end

  assign victim = pick(tree[rd_idx]);

endmodule

// File: rtl/rfphoenix_ichit_plru.sv
// Two-stage I-cache hit / way-select with per-line valid bits and tree PLRU victim choice.
// Optional multihit detection and counter enabled by defining RFPHOENIX_ICHIT_MULTIHIT_EN.
module rfphoenix_ichit_plru
  import rfphoenix_ichit_plru_pkg::*;
#(
  parameter  int LINES = ICACHE_LINES,
  parameter  int WAYS  = ICACHE_WAYS,
  parameter  int AWID  = ICACHE_AWID,
  parameter  int LOBIT = ICACHE_LOBIT,
  localparam int IDXW  = $clog2(LINES),
  localparam int WAYW  = $clog2(WAYS),
  localparam int TAGW  = AWID - LOBIT
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ip_v,
  input  logic [AWID-1:0]           ip,
  input  logic [WAYS-1:0][TAGW-1:0] tag,
  input  logic                      fill_v,
  input  logic [IDXW-1:0]           fill_idx,
  input  logic [WAYW-1:0]           fill_way,
  input  logic                      inv_v,
  input  logic                      inv_all,
  input  logic [IDXW-1:0]           inv_idx,
  output logic                      ihit_v,
  output logic                      ihit,
  output logic [WAYW-1:0]           hit_way,
  output logic [TAGW-1:0]           vtag,
  output logic [WAYW-1:0]           victim_way,
  output logic                      icv
`ifdef RFPHOENIX_ICHIT_MULTIHIT_EN
  ,
  output logic                      multihit,
  output logic [7:0]                mh_count
`endif
);

  logic [WAYS-1:0]           valid [LINES];
  logic [IDXW-1:0]           idx0, idx1, idx2;
  logic [TAGW-1:0]           itag;
  logic [WAYS-1:0]           vrow, hit0, hit1, valid1;
  logic [WAYS-1:0][TAGW-1:0] tag1;
  logic                      v1, anyv1;
  logic [WAYW-1:0]           hsel, vsel, plru_victim;
  logic                      unused_lo;

  assign idx0      = ip[LOBIT+IDXW-1:LOBIT];
  assign itag      = ip[AWID-1:LOBIT];
  assign vrow      = valid[idx0];
  assign unused_lo = ^ip[LOBIT-1:0];

  // Later assignments win: a same-set invalidate overrides a fill, inv_all overrides both.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LINES; i++) valid[i] <= '0;
    end else if (inv_v && inv_all) begin
      for (int i = 0; i < LINES; i++) valid[i] <= '0;
    end else begin
      if (fill_v) valid[fill_idx][fill_way] <= 1'b1;
      if (inv_v)  valid[inv_idx]            <= '0;
    end
  end

  always_comb begin
    hit0 = '0;
    for (int w = 0; w < WAYS; w++) hit0[w] = (tag[w] == itag) && vrow[w];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1     <= 1'b0;
      hit1   <= '0;
      idx1   <= '0;
      anyv1  <= 1'b0;
      valid1 <= '0;
      tag1   <= '0;
    end else begin
      v1     <= ip_v;
      hit1   <= hit0;
      idx1   <= idx0;
      anyv1  <= |vrow;
      valid1 <= vrow;
      tag1   <= tag;
    end
  end

  // Highest hitting way wins; lowest invalid way is refilled before consulting the tree.
  always_comb begin
    hsel = '0;
    for (int w = 0; w < WAYS; w++) if (hit1[w]) hsel = WAYW'(w);
    vsel = plru_victim;
    for (int w = WAYS - 1; w >= 0; w--) if (!valid1[w]) vsel = WAYW'(w);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ihit_v     <= 1'b0;
      ihit       <= 1'b0;
      icv        <= 1'b0;
      hit_way    <= '0;
      vtag       <= '0;
      victim_way <= '0;
      idx2       <= '0;
    end else begin
      ihit_v     <= v1;
      ihit       <= |hit1;
      icv        <= anyv1;
      victim_way <= vsel;
      idx2       <= idx1;
      if (v1 && (|hit1)) begin
        hit_way <= hsel;
        vtag    <= tag1[hsel];
      end
    end
  end

  rfphoenix_plru_tree #(
    .LINES (LINES),
    .WAYS  (WAYS)
  ) u_plru (
    .clk      (clk),
    .rst_n    (rst_n),
    .hit_v    (ihit_v && ihit),
    .hit_idx  (idx2),
    .hit_way  (hit_way),
    .fill_v   (fill_v),
    .fill_idx (fill_idx),
    .fill_way (fill_way),
    .rd_idx   (idx1),
    .victim   (plru_victim)
  );

`ifdef RFPHOENIX_ICHIT_MULTIHIT_EN
  logic mh1;

  // Clearing the lowest set bit leaves something only when two or more ways hit.
  assign mh1 = |(hit1 & (hit1 - WAYS'(1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      multihit <= 1'b0;
      mh_count <= '0;
    end else begin
      multihit <= v1 && mh1;
      if (v1 && mh1 && (mh_count != 8'hff)) mh_count <= mh_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rfphoenix_ichit_plru.sv
// Scoreboard bench for rfphoenix_ichit_plru; covers RFPHOENIX_ICHIT_MULTIHIT_EN when defined.
module tb_rfphoenix_ichit_plru;
  import rfphoenix_ichit_plru_pkg::*;

  localparam int LINES = ICACHE_LINES;
  localparam int WAYS  = ICACHE_WAYS;
  localparam int AWID  = ICACHE_AWID;
  localparam int LOBIT = ICACHE_LOBIT;
  localparam int IDXW  = $clog2(LINES);
  localparam int TAGW  = AWID - LOBIT;

  typedef logic [WAYS-1:0][TAGW-1:0] tagvec_t;

  typedef struct {
    bit              hit;
    int              way;
    logic [TAGW-1:0] vtag;
    bit              icv;
    int              victim;
    bit              mh;
    int              mhCount;
  } exp_t;

  typedef struct {
    bit              v;
    int              idx;
    bit              hit;
    int              way;
    int              nhits;
    logic [TAGW-1:0] t;
    bit [WAYS-1:0]   vsnap;
    bit              icv;
  } look_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            ip_v = 1'b0;
  logic [AWID-1:0] ip = '0;
  tagvec_t         tag = '0;
  logic            fill_v = 1'b0;
  logic [IDXW-1:0] fill_idx = '0;
  ic_way_t         fill_way = '0;
  logic            inv_v = 1'b0;
  logic            inv_all = 1'b0;
  logic [IDXW-1:0] inv_idx = '0;
  logic            ihit_v, ihit, icv;
  ic_way_t         hit_way, victim_way;
  ic_tag_t         vtag;
`ifdef RFPHOENIX_ICHIT_MULTIHIT_EN
  logic            multihit;
  logic [7:0]      mh_count;
`endif

  int     tests = 0;
  int     failures = 0;
  exp_t   expQ[$];
  bit     mvalid [LINES][WAYS];
  longint lastTouch [LINES][WAYS];
  int     edgeCount = 0;
  int     lastWay = 0;
  logic [TAGW-1:0] lastTag = '0;
  int     mhCount = 0;
  look_t  s1, s2;

  rfphoenix_ichit_plru dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ip_v       (ip_v),
    .ip         (ip),
    .tag        (tag),
    .fill_v     (fill_v),
    .fill_idx   (fill_idx),
    .fill_way   (fill_way),
    .inv_v      (inv_v),
    .inv_all    (inv_all),
    .inv_idx    (inv_idx),
    .ihit_v     (ihit_v),
    .ihit       (ihit),
    .hit_way    (hit_way),
    .vtag       (vtag),
    .victim_way (victim_way),
    .icv        (icv)
`ifdef RFPHOENIX_ICHIT_MULTIHIT_EN
    ,
    .multihit   (multihit),
    .mh_count   (mh_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string name, input longint act, input longint req);
    tests++;
    if (act != req) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Tree PLRU as a rule: at each subtree, steer away from the half holding the most recent touch.
  function automatic int plruVictim(input int set);
    int     lo, size, half, bestWay;
    longint best;
    lo   = 0;
    size = WAYS;
    while (size > 1) begin
      half    = size / 2;
      best    = 0;
      bestWay = -1;
      for (int w = lo; w < lo + size; w++)
        if (lastTouch[set][w] > best) begin
          best    = lastTouch[set][w];
          bestWay = w;
        end
      if (bestWay >= lo && bestWay < lo + half) lo = lo + half;
      size = half;
    end
    return lo;
  endfunction

  // Reference model: snapshots lookups at the edge they are sampled and queues the response.
  always @(posedge clk or negedge rst_n) begin
    look_t n1;
    exp_t  e;
    if (!rst_n) begin
      for (int s = 0; s < LINES; s++)
        for (int w = 0; w < WAYS; w++) begin
          mvalid[s][w]    = 1'b0;
          lastTouch[s][w] = 0;
        end
      expQ.delete();
      s1.v    = 1'b0;
      s2.v    = 1'b0;
      lastWay = 0;
      lastTag = '0;
      mhCount = 0;
    end else begin
      edgeCount++;
      n1.v     = ip_v;
      n1.idx   = int'(ip[LOBIT+IDXW-1:LOBIT]);
      n1.t     = ip[AWID-1:LOBIT];
      n1.hit   = 1'b0;
      n1.way   = 0;
      n1.nhits = 0;
      n1.icv   = 1'b0;
      for (int w = 0; w < WAYS; w++) begin
        n1.vsnap[w] = mvalid[n1.idx][w];
        if (mvalid[n1.idx][w]) n1.icv = 1'b1;
        if (mvalid[n1.idx][w] && tag[w] == n1.t) begin
          n1.hit = 1'b1;
          n1.way = w;
          n1.nhits++;
        end
      end
      if (s1.v) begin
        e.hit = s1.hit;
        e.icv = s1.icv;
        if (s1.hit) begin
          lastWay = s1.way;
          lastTag = s1.t;
        end
        e.way    = lastWay;
        e.vtag   = lastTag;
        e.victim = -1;
        for (int w = 0; w < WAYS; w++) if (!s1.vsnap[w] && e.victim < 0) e.victim = w;
        if (e.victim < 0) e.victim = plruVictim(s1.idx);
        e.mh = (s1.nhits > 1);
        if (e.mh && mhCount < 255) mhCount++;
        e.mhCount = mhCount;
        expQ.push_back(e);
      end
      if (s2.v && s2.hit) lastTouch[s2.idx][s2.way] = longint'(edgeCount) * 2;
      if (fill_v) lastTouch[fill_idx][fill_way] = longint'(edgeCount) * 2 + 1;
      if (inv_v && inv_all) begin
        for (int s = 0; s < LINES; s++)
          for (int w = 0; w < WAYS; w++) mvalid[s][w] = 1'b0;
      end else begin
        if (fill_v) mvalid[fill_idx][fill_way] = 1'b1;
        if (inv_v) for (int w = 0; w < WAYS; w++) mvalid[inv_idx][w] = 1'b0;
      end
      s2 = s1;
      s1 = n1;
    end
  end

  task automatic checkOutput(input exp_t e);
    checkVal("ihit", longint'(ihit), longint'(e.hit));
    checkVal("hit_way", longint'(hit_way), longint'(e.way));
    checkVal("vtag", longint'(vtag), longint'(e.vtag));
    checkVal("icv", longint'(icv), longint'(e.icv));
    checkVal("victim_way", longint'(victim_way), longint'(e.victim));
`ifdef RFPHOENIX_ICHIT_MULTIHIT_EN
    checkVal("multihit", longint'(multihit), longint'(e.mh));
    checkVal("mh_count", longint'(mh_count), longint'(e.mhCount));
`endif
  endtask

  // Monitor: every cycle out of reset, ihit_v must match whether a response is due.
  always @(negedge clk) begin
    bit   expV;
    exp_t e;
    if (rst_n) begin
      expV = (expQ.size() > 0);
      checkVal("ihit_v", longint'(ihit_v === 1'b1), longint'(expV));
      if (expV) begin
        e = expQ.pop_front();
        if (ihit_v === 1'b1) checkOutput(e);
      end
    end
  end

  function automatic tagvec_t makeTags(input logic [AWID-1:0] a, input logic [WAYS-1:0] m);
    tagvec_t t;
    for (int w = 0; w < WAYS; w++)
      t[w] = m[w] ? a[AWID-1:LOBIT] : (a[AWID-1:LOBIT] ^ TAGW'($urandom_range(1, 4095)));
    return t;
  endfunction

  function automatic logic [AWID-1:0] mkAddr(input int hi, input int set);
    return (AWID'(hi) << (LOBIT + IDXW)) | (AWID'(set) << LOBIT) |
           AWID'($urandom_range(0, (1 << LOBIT) - 1));
  endfunction

  task automatic applyStimulus(input bit lv, input logic [AWID-1:0] lip, input tagvec_t ltag,
                               input bit fv, input int fidx, input int fway,
                               input bit iv, input bit iall, input int iidx);
    ip_v     = lv;
    ip       = lip;
    tag      = ltag;
    fill_v   = fv;
    fill_idx = IDXW'(fidx);
    fill_way = ic_way_t'(fway);
    inv_v    = iv;
    inv_all  = iall;
    inv_idx  = IDXW'(iidx);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, '0, '0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic lookup(input logic [AWID-1:0] a, input logic [WAYS-1:0] m);
    applyStimulus(1, a, makeTags(a, m), 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, required finish before %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [AWID-1:0] a;
    @(negedge clk);
    @(negedge clk);
    checkVal("reset_ihit_v", longint'(ihit_v), 0);
    checkVal("reset_ihit", longint'(ihit), 0);
    checkVal("reset_hit_way", longint'(hit_way), 0);
    checkVal("reset_vtag", longint'(vtag), 0);
    checkVal("reset_victim", longint'(victim_way), 0);
    checkVal("reset_icv", longint'(icv), 0);
`ifdef RFPHOENIX_ICHIT_MULTIHIT_EN
    checkVal("reset_multihit", longint'(multihit), 0);
    checkVal("reset_mh_count", longint'(mh_count), 0);
`endif
    #2 rst_n = 1'b1;
    @(negedge clk);

    applyStimulus(0, '0, '0, 1, 5, 2, 0, 0, 0);
    lookup(32'h0000_0140, 4'b0100);
    idle(1);
    checkVal("tp1_ihit", longint'(ihit), 1);
    checkVal("tp1_hit_way", longint'(hit_way), 2);
    checkVal("tp1_vtag", longint'(vtag), 5);
    checkVal("tp1_icv", longint'(icv), 1);

    lookup(32'h0000_01C0, 4'b0000);
    idle(1);
    checkVal("tp2_ihit", longint'(ihit), 0);
    checkVal("tp2_icv", longint'(icv), 0);
    checkVal("tp2_victim", longint'(victim_way), 0);
    checkVal("tp2_hit_way_hold", longint'(hit_way), 2);
    checkVal("tp2_vtag_hold", longint'(vtag), 5);

    for (int w = 0; w < WAYS; w++) applyStimulus(0, '0, '0, 1, 3, w, 0, 0, 0);
    for (int w = 0; w < WAYS; w++) begin
      lookup(32'h0000_00C0, WAYS'(1) << w);
      idle(2);
    end
    lookup(32'h0000_00C0, 4'b0000);
    idle(2);

    applyStimulus(0, '0, '0, 1, 9, 1, 1, 0, 9);
    lookup(32'h0000_0240, 4'b0010);
    idle(1);
    checkVal("tp4_ihit", longint'(ihit), 0);
    checkVal("tp4_icv", longint'(icv), 0);

    for (int s = 20; s < 23; s++) applyStimulus(0, '0, '0, 1, s, s % WAYS, 0, 0, 0);
    for (int s = 20; s < 23; s++) begin
      a = mkAddr(0, s);
      applyStimulus(1, a, makeTags(a, 4'b1111), 0, 0, 0, (s == 22), 1, 0);
    end
    for (int s = 20; s < 23; s++) lookup(mkAddr(0, s), 4'b1111);
    lookup(32'h0000_0140, 4'b1111);
    idle(2);
    checkVal("tp5_icv_after_inv_all", longint'(icv), 0);

`ifdef RFPHOENIX_ICHIT_MULTIHIT_EN
    applyStimulus(0, '0, '0, 1, 11, 1, 0, 0, 0);
    applyStimulus(0, '0, '0, 1, 11, 3, 0, 0, 0);
    lookup(mkAddr(0, 11), 4'b1010);
    idle(1);
    checkVal("tp6_hit_way", longint'(hit_way), 3);
    checkVal("tp6_multihit", longint'(multihit), 1);
    checkVal("tp6_mh_count", longint'(mh_count), 1);
`endif

    for (int c = 0; c < 4000; c++) begin
      int  set, fidx, iidx;
      bit  lv, fv, iv, iall;
      set  = ($urandom_range(0, 9) == 0) ? $urandom_range(0, LINES - 1) : $urandom_range(0, 7);
      fidx = ($urandom_range(0, 9) == 0) ? $urandom_range(0, LINES - 1) : $urandom_range(0, 7);
      iidx = $urandom_range(0, 7);
      lv   = ($urandom_range(0, 9) < 7);
      fv   = ($urandom_range(0, 99) < 35);
      iv   = ($urandom_range(0, 99) < 4);
      iall = iv && ($urandom_range(0, 9) == 0);
      a    = mkAddr($urandom_range(0, 1), set);
      if (c == 2000) begin
        lookup(a, 4'b1111);
        lookup(a, 4'b0001);
        #2 rst_n = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
      end
      applyStimulus(lv, a, makeTags(a, WAYS'($urandom_range(0, (1 << WAYS) - 1))),
                    fv, fidx, $urandom_range(0, WAYS - 1), iv, iall, iidx);
    end

    idle(5);
    checkVal("drain_queue_empty", longint'(expQ.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
